// File: rtl/tboom_freelist_mc.sv
// ---------------------------------------------------------------------------
// tboom_freelist_mc
//
// Physical-register freelist for the TinyBOOM rename stage. A circular RAM
// holds the free physical registers. Three pointers index into it:
//   spec_head   : next entry handed to rename (speculative)
//   commit_head : spec_head as it would be if only committed work had allocated
//   tail        : next slot where committed stale registers are returned
// Each pointer carries one extra wrap bit, so tail - spec_head is the free count.
// Up to NUM_CKPT branch checkpoints store a copy of spec_head. A mispredict
// restores spec_head from one slot. An exception restores it to commit_head.
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   alloc_req_valid     : per-lane allocation request
//   alloc_pdst_valid    : per-lane grant (combinational from registered state)
//   alloc_pdst          : granted register, lane k in [k*W +: W]
//   commit_valid        : per-lane commit of a destination-writing instruction
//   commit_pdst_old     : stale register to return, lane k in [k*W +: W]
//   ckpt_valid/ckpt_id  : capture post-grant spec_head into a slot
//   ckpt_release_*      : branch resolved correct, invalidate the slot
//   flush_valid/flush_id: mispredict, restore spec_head from a valid slot
//   flush_all           : exception, restore spec_head to the committed head
//   freelist_count      : free entries
//   freelist_empty      : count == 0
//   freelist_low        : count < ALLOC_WIDTH
// ---------------------------------------------------------------------------
module tboom_freelist_mc #(
    parameter int REG_PHYS_ADDR_WIDTH = 6,
    parameter int NUM_PHYS_REGISTERS  = 64,
    parameter int NUM_ARCH_REGISTERS  = 32,
    parameter int ALLOC_WIDTH         = 2,
    parameter int COMMIT_WIDTH        = 2,
    parameter int NUM_CKPT            = 4,
    localparam int CKPT_ID_WIDTH      = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int DEPTH              = NUM_PHYS_REGISTERS - NUM_ARCH_REGISTERS,
    localparam int PTR_W              = $clog2(DEPTH) + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [ALLOC_WIDTH-1:0]                   alloc_req_valid,
    output logic [ALLOC_WIDTH-1:0]                   alloc_pdst_valid,
    output logic [ALLOC_WIDTH*REG_PHYS_ADDR_WIDTH-1:0]  alloc_pdst,
    input  logic [COMMIT_WIDTH-1:0]                  commit_valid,
    input  logic [COMMIT_WIDTH*REG_PHYS_ADDR_WIDTH-1:0] commit_pdst_old,
    input  logic                                     ckpt_valid,
    input  logic [CKPT_ID_WIDTH-1:0]                 ckpt_id,
    input  logic                                     ckpt_release_valid,
    input  logic [CKPT_ID_WIDTH-1:0]                 ckpt_release_id,
    input  logic                                     flush_valid,
    input  logic [CKPT_ID_WIDTH-1:0]                 flush_id,
    input  logic                                     flush_all,
    output logic [PTR_W-1:0]                         freelist_count,
    output logic                                     freelist_empty,
    output logic                                     freelist_low
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  DEPTH_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LOW_MARK  = PTR_W'(ALLOC_WIDTH);

    // The wrap-bit pointer scheme needs DEPTH to be a power of two.
    if ((DEPTH <= 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("tboom_freelist_mc: NUM_PHYS_REGISTERS - NUM_ARCH_REGISTERS must be a power of two");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REG_PHYS_ADDR_WIDTH-1:0] r_ram [DEPTH];
    logic [PTR_W-1:0]               r_spec_head;
    logic [PTR_W-1:0]               r_commit_head;
    logic [PTR_W-1:0]               r_tail;
    logic [PTR_W-1:0]               r_slot_head  [NUM_CKPT];
    logic                           r_slot_valid [NUM_CKPT];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] w_count;
    logic             w_flush_ckpt;
    logic             w_any_flush;
    logic [PTR_W-1:0] w_req_acc;
    logic [PTR_W-1:0] w_grant_cnt;
    logic [IDX_W-1:0] w_alloc_idx  [ALLOC_WIDTH];
    logic [PTR_W-1:0] w_commit_cnt;
    logic [IDX_W-1:0] w_commit_idx [COMMIT_WIDTH];
    logic [PTR_W-1:0] w_spec_after_alloc;

    assign w_count = r_tail - r_spec_head;

    // A mispredict naming an invalid slot has no effect at all.
    assign w_flush_ckpt = flush_valid && r_slot_valid[flush_id];
    assign w_any_flush  = flush_all || w_flush_ckpt;

    // Allocation lanes are compacted: lane k reads the entry offset by the
    // number of requesting lanes below it. Because ranks are dense, the
    // granted lanes always form the lowest min(requests, count) requesters.
    always_comb begin
        w_req_acc        = '0;
        w_grant_cnt      = '0;
        alloc_pdst_valid = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            w_alloc_idx[k] = IDX_W'(r_spec_head + w_req_acc);
            if (alloc_req_valid[k] && (w_req_acc < w_count) && !w_any_flush) begin
                alloc_pdst_valid[k] = 1'b1;
                w_grant_cnt         = w_grant_cnt + PTR_W'(1);
            end
            w_req_acc = w_req_acc + PTR_W'(alloc_req_valid[k]);
        end
    end

    for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_lane
        assign alloc_pdst[gi*REG_PHYS_ADDR_WIDTH +: REG_PHYS_ADDR_WIDTH] = r_ram[w_alloc_idx[gi]];
    end

    // Commit lanes are compacted at the tail in lane order.
    always_comb begin
        w_commit_cnt = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            w_commit_idx[j] = IDX_W'(r_tail + w_commit_cnt);
            w_commit_cnt    = w_commit_cnt + PTR_W'(commit_valid[j]);
        end
    end

    assign w_spec_after_alloc = r_spec_head + w_grant_cnt;

    assign freelist_count = w_count;
    assign freelist_empty = (w_count == '0);
    assign freelist_low   = (w_count < LOW_MARK);

    // ------------------------------------------------------------------
    // Freelist RAM: reset image p(NUM_ARCH)..p(NUM_PHYS-1); commits write
    // at the tail. Writes become readable next cycle (no bypass).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= REG_PHYS_ADDR_WIDTH'(NUM_ARCH_REGISTERS + i);
            end
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (commit_valid[j]) begin
                    r_ram[w_commit_idx[j]] <= commit_pdst_old[j*REG_PHYS_ADDR_WIDTH +: REG_PHYS_ADDR_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers. Commits are applied every cycle, flush or not.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= DEPTH_PTR;   // full: wrap bit set, index 0
        end else begin
            r_tail        <= r_tail + w_commit_cnt;
            r_commit_head <= r_commit_head + w_commit_cnt;
            if (flush_all) begin
                // Includes this cycle's commits so the restored head matches
                // the committed allocation point after the edge.
                r_spec_head <= r_commit_head + w_commit_cnt;
            end else if (w_flush_ckpt) begin
                r_spec_head <= r_slot_head[flush_id];
            end else begin
                r_spec_head <= w_spec_after_alloc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checkpoint slots. Capture beats a same-cycle release of the same id;
    // any flush suppresses capture. A mispredict only invalidates its own
    // slot; younger tags are released by the caller.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_CKPT; s++) begin
                r_slot_valid[s] <= 1'b0;
                r_slot_head[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_CKPT; s++) begin
                if (flush_all) begin
                    r_slot_valid[s] <= 1'b0;
                end else if (w_flush_ckpt && (flush_id == CKPT_ID_WIDTH'(s))) begin
                    r_slot_valid[s] <= 1'b0;
                end else if (!w_any_flush && ckpt_valid && (ckpt_id == CKPT_ID_WIDTH'(s))) begin
                    r_slot_valid[s] <= 1'b1;
                    r_slot_head[s]  <= w_spec_after_alloc;
                end else if (ckpt_release_valid && (ckpt_release_id == CKPT_ID_WIDTH'(s))) begin
                    r_slot_valid[s] <= 1'b0;
                end
            end
        end
    end

    // The freelist can never hold more entries than it has slots.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) w_count <= DEPTH_PTR);

endmodule

// File: doc/tboom_freelist_mc.md
# tboom_freelist_mc

Parametrised N-wide physical-register freelist for the TinyBOOM rename stage, with multiple branch checkpoints. It generalises the dual-lane, single-checkpoint freelist to ALLOC_WIDTH allocation lanes, COMMIT_WIDTH free lanes and NUM_CKPT independently addressable checkpoint slots. It adds full-pipeline rollback to the committed state for exceptions. It sits between decode/rename (allocation, checkpoint) and the ROB (commit frees, flush).

## Interface
- REG_PHYS_ADDR_WIDTH, 6, physical register index width
- NUM_PHYS_REGISTERS, 64, total physical registers
- NUM_ARCH_REGISTERS, 32, registers p0..p(NUM_ARCH-1) mapped at reset, never initially free
- ALLOC_WIDTH, 2, allocation lanes
- COMMIT_WIDTH, 2, free lanes
- NUM_CKPT, 4, checkpoint slots; CKPT_ID_WIDTH = $clog2(NUM_CKPT) derived
- DEPTH = NUM_PHYS_REGISTERS - NUM_ARCH_REGISTERS, derived; must be a power of two (elaboration error otherwise)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req_valid  in  ALLOC_WIDTH  per-lane allocation request
- alloc_pdst_valid  out  ALLOC_WIDTH  per-lane grant
- alloc_pdst  out  ALLOC_WIDTH*REG_PHYS_ADDR_WIDTH  granted register, lane k in bits [k*W +: W]
- commit_valid  in  COMMIT_WIDTH  per-lane commit of a destination-writing instruction
- commit_pdst_old  in  COMMIT_WIDTH*REG_PHYS_ADDR_WIDTH  stale register to free
- ckpt_valid  in  1  capture checkpoint
- ckpt_id  in  CKPT_ID_WIDTH  slot to capture into
- ckpt_release_valid, ckpt_release_id  in  1, CKPT_ID_WIDTH  branch resolved correct; invalidate slot
- flush_valid, flush_id  in  1, CKPT_ID_WIDTH  mispredict; restore head from slot
- flush_all  in  1  exception; restore head to committed head
- freelist_count  out  $clog2(DEPTH)+1  free entries
- freelist_empty  out  1  count == 0
- freelist_low  out  1  count < ALLOC_WIDTH

## Operation
- Storage: DEPTH-entry circular RAM; pointers spec_head, commit_head, tail, each $clog2(DEPTH)+1 bits (MSB = wrap bit); count = tail - spec_head.
- Reset: entry i = NUM_ARCH_REGISTERS + i; all pointers 0 except tail = DEPTH (full, wrap bit set); all checkpoint slots invalid.
- Allocation: lane k requesting gets entry at spec_head + r_k, r_k = requesting lanes below k (compacted). Granted iff r_k < count and no flush this cycle. spec_head advances by grant count.
- Frees: valid commit lanes written compacted at tail in lane order; tail += popcount(commit_valid). commit_head += popcount(commit_valid).
- Checkpoint: slot[ckpt_id] <= spec_head after this cycle's grants; slot valid set; overwrite of valid slot allowed.
- Release: clears slot valid. Same-cycle capture to same id wins.
- flush_valid on valid slot: spec_head <= slot head; slot invalidated; other slots untouched (caller releases younger tags). On invalid slot: ignored.
- flush_all: spec_head <= commit_head after this cycle's commits; all slots invalidated.
- Priority: flush_all > flush_valid > ckpt_valid/allocation. During any flush, grants are 0 and ckpt_valid is ignored. Commits always processed.
- Simulation assertion: count never exceeds DEPTH.

## Timing
- Grants combinational same cycle from registered state; pointer and RAM updates at rising edge.
- Freed registers allocatable the cycle after commit (no same-cycle bypass).
- Flush takes effect next cycle; first post-flush grant = restored head entry.
- Reset outputs: alloc_pdst_valid 0 when no request, freelist_count = DEPTH, freelist_empty 0, freelist_low 0.
- Async reset mid-operation discards all state immediately.

## Test plan
- Reset, both lanes request -> grants p32, p33; count 32 -> 30 next cycle.
- Lane 0 idle, lane 1 requests -> lane 1 gets p32 (compaction); lane 0 pdst_valid 0.
- Checkpoint slot 2 after p32,p33; allocate p34..p37; flush_id 2 -> next grants p34,p35. Flush of invalid slot 1 leaves head unchanged.
- Commit p5,p6 with two instructions; drain to empty -> last grants p62,p63, then p5,p6; freelist_empty when count 0; lane 1 denied when count 1.
- Allocate 4, commit 2, flush_all -> spec_head = commit_head; next grants are 3rd and 4th originally allocated; all slots invalid.
- Simultaneous flush + alloc + commit -> no grants, commits applied, count correct next cycle.
